fp_addsub_arbiter: RTL and testbench

- Shares one floating-point add/sub datapath (IEEE 754 single precision, WIDTH=32) among NREQ requesters.
- Round-robin grant over per-requester valid/ready requests; latches the operands and pulses a start to the datapath.
- Waits for datapath completion under a timeout watchdog, then returns the result to the granted requester on a per-requester valid/ready response channel.
- Sits between the requester ports and the add/sub core; one operation in flight at a time.

---
 rtl/fp_addsub_arbiter_pkg.sv | 12 +
 rtl/fp_addsub_arbiter_if.sv | 35 +++
 rtl/fp_addsub_arbiter_rr_arbiter.sv | 38 +++
 rtl/fp_addsub_arbiter.sv | 134 +++++++++++++
 tb/tb_fp_addsub_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_addsub_arbiter_pkg.sv
// Shared definitions for the floating-point add/sub arbiter slice.
//   fp_arb_state_t  : FSM state encoding (IDLE, ISSUE, WAIT, RESP)
//   FP_QNAN         : canonical single-precision quiet NaN returned on abort
//   ARB_TIMEOUT_DEF : default watchdog length in WAIT cycles
package fp_addsub_arbiter_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} fp_arb_state_t;

   localparam logic [31:0] FP_QNAN         = 32'h7FC0_0000;
   localparam int          ARB_TIMEOUT_DEF = 64;

endpackage

// File: rtl/fp_addsub_arbiter_if.sv
// Bus bundle between the requesters / add-sub core and the arbiter.
//   req_*  : per-requester request channel (valid/ready, packed operands)
//   core_* : operand latch, start pulse and completion from the shared core
//   rsp_*  : per-requester response channel with shared result/error
// Modports: master = requester + core environment, slave = arbiter.
interface fp_addsub_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_op;
   logic [WIDTH-1:0]      core_a;
   logic [WIDTH-1:0]      core_b;
   logic                  core_op;
   logic                  core_start;
   logic                  core_done;
   logic [WIDTH-1:0]      core_result;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [WIDTH-1:0]      rsp_result;
   logic                  rsp_err;

   modport master (
      output req_valid, req_a, req_b, req_op, core_done, core_result, rsp_ready,
      input  req_ready, core_a, core_b, core_op, core_start, rsp_valid, rsp_result, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, core_done, core_result, rsp_ready,
      output req_ready, core_a, core_b, core_op, core_start, rsp_valid, rsp_result, rsp_err
   );
endinterface

// File: rtl/fp_addsub_arbiter_rr_arbiter.sv
// Combinational round-robin priority encoder.
//   req        : request vector
//   ptr        : index with highest priority this cycle
//   gnt_onehot : one-hot grant (all zero when no request)
//   gnt_idx    : index of the granted request
//   gnt_any    : at least one request present
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt_onehot,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_any
);

   logic [IW-1:0] idx;

   // Walk from the lowest priority offset down to ptr itself so the
   // closest request at or after ptr is the last (winning) assignment.
   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      gnt_any    = 1'b0;
      idx        = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = IW'((int'(ptr) + k) % N);
         if (req[idx]) begin
            gnt_onehot      = '0;
            gnt_onehot[idx] = 1'b1;
            gnt_idx         = idx;
            gnt_any         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one IEEE-754 single-precision add/sub core among NREQ requesters.
// Round-robin accept, one operation in flight, timeout watchdog in WAIT.
//   clk, rst : clock and synchronous active-high reset
//   bus      : request, core and response channels (slave side)
//   busy     : FSM is not in IDLE
//   op_count : completed operations (success or abort), saturating
module fp_addsub_arbiter
   import fp_addsub_arbiter_pkg::*;
#(
   parameter  int NREQ    = 4,
   parameter  int WIDTH   = 32,
   parameter  int TIMEOUT = ARB_TIMEOUT_DEF,
   localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                clk,
   input  logic                rst,
   fp_addsub_arbiter_if.slave  bus,
   output logic                busy,
   output logic [15:0]         op_count
);

   localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] S_IDLE  = 2'(IDLE);
   localparam logic [1:0] S_ISSUE = 2'(ISSUE);
   localparam logic [1:0] S_WAIT  = 2'(WAIT);
   localparam logic [1:0] S_RESP  = 2'(RESP);

   logic [1:0]       state;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   grant_id;
   logic [WCW-1:0]   wait_cnt;
   logic [WIDTH-1:0] core_a_q, core_b_q, rsp_result_q;
   logic             core_op_q, rsp_err_q;

   logic [NREQ-1:0]  gnt_onehot;
   logic [IDW-1:0]   gnt_idx;
   logic             gnt_any;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic             sel_op;
   logic [NREQ-1:0]  rsp_valid_c;

   rr_arbiter #(.N(NREQ)) u_rr (
      .req        (bus.req_valid),
      .ptr        (rr_ptr),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .gnt_any    (gnt_any)
   );

   // Operand mux for the current grant
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == IDW'(i)) begin
            sel_a  = bus.req_a[i*WIDTH +: WIDTH];
            sel_b  = bus.req_b[i*WIDTH +: WIDTH];
            sel_op = bus.req_op[i];
         end
      end
   end

   always_comb begin
      rsp_valid_c           = '0;
      rsp_valid_c[grant_id] = (state == S_RESP);
   end

   assign bus.req_ready  = (state == S_IDLE) ? gnt_onehot : '0;
   assign bus.rsp_valid  = rsp_valid_c;
   assign bus.core_start = (state == S_ISSUE);
   assign bus.core_a     = core_a_q;
   assign bus.core_b     = core_b_q;
   assign bus.core_op    = core_op_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_err    = rsp_err_q;
   assign busy           = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         rr_ptr       <= '0;
         grant_id     <= '0;
         wait_cnt     <= '0;
         op_count     <= '0;
         core_a_q     <= '0;
         core_b_q     <= '0;
         core_op_q    <= 1'b0;
         rsp_result_q <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // req_ready follows the grant, so any grant is a handshake
               if (gnt_any) begin
                  core_a_q  <= sel_a;
                  core_b_q  <= sel_b;
                  core_op_q <= sel_op;
                  grant_id  <= gnt_idx;
                  rr_ptr    <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wait_cnt <= '0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               // Completion takes priority over a coincident timeout
               if (bus.core_done) begin
                  rsp_result_q <= bus.core_result;
                  rsp_err_q    <= 1'b0;
                  state        <= S_RESP;
               end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
                  rsp_result_q <= WIDTH'(FP_QNAN);
                  rsp_err_q    <= 1'b1;
                  state        <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end
            end
            S_RESP: begin
               if (bus.rsp_ready[grant_id]) begin
                  if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Directed self-checking bench for fp_addsub_arbiter (NREQ=4, TIMEOUT=64).
// The bench plays both the requesters and the add/sub core.
module tb_fp_addsub_arbiter;

   logic        clk;
   logic        rst;
   logic        busy;
   logic [15:0] op_count;
   int          n_cmp;
   int          n_err;
   logic [31:0] ta [4];
   logic [31:0] tb [4];
   logic [31:0] held;

   fp_addsub_arbiter_if #(.NREQ(4), .WIDTH(32)) bus ();

   fp_addsub_arbiter #(.NREQ(4), .WIDTH(32), .TIMEOUT(64)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .op_count (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full operation with all requesters valid and rsp_ready high;
   // entered in an IDLE cycle, leaves in the following IDLE cycle.
   task automatic rr_op(input int id, input logic [31:0] res);
      chk("rr_req_ready", 32'(bus.req_ready), 32'(4'b0001 << id));
      cyc();
      chk("rr_start", 32'(bus.core_start), 32'd1);
      chk("rr_core_a", bus.core_a, ta[id]);
      chk("rr_core_b", bus.core_b, tb[id]);
      chk("rr_core_op", 32'(bus.core_op), 32'(id % 2));
      cyc();
      bus.core_done   = 1'b1;
      bus.core_result = res;
      cyc();
      bus.core_done = 1'b0;
      chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'(4'b0001 << id));
      chk("rr_rsp_result", bus.rsp_result, res);
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 4; i++) begin
         ta[i] = 32'h4100_0000 + 32'(i);
         tb[i] = 32'h4200_0000 + 32'(i);
      end
      rst             = 1'b1;
      bus.req_valid   = '0;
      bus.req_a       = '0;
      bus.req_b       = '0;
      bus.req_op      = '0;
      bus.core_done   = 1'b0;
      bus.core_result = '0;
      bus.rsp_ready   = '0;
      cyc();
      cyc();

      // Reset state
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_core_start", 32'(bus.core_start), 32'd0);
      chk("rst_core_a", bus.core_a, 32'd0);
      chk("rst_rsp_result", bus.rsp_result, 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      rst = 1'b0;
      cyc();

      // Single request: 1.0 + 2.0 = 3.0
      bus.req_valid     = 4'b0001;
      bus.req_a[31:0]   = 32'h3F80_0000;
      bus.req_b[31:0]   = 32'h4000_0000;
      bus.req_op[0]     = 1'b0;
      #1;
      chk("s_req_ready", 32'(bus.req_ready), 32'h1);
      cyc();                                   // T+1
      bus.req_valid = '0;
      chk("s_start", 32'(bus.core_start), 32'd1);
      chk("s_busy", 32'(busy), 32'd1);
      chk("s_core_a", bus.core_a, 32'h3F80_0000);
      chk("s_core_b", bus.core_b, 32'h4000_0000);
      chk("s_core_op", 32'(bus.core_op), 32'd0);
      cyc();                                   // T+2
      chk("s_start_once", 32'(bus.core_start), 32'd0);
      chk("s_no_rsp_yet", 32'(bus.rsp_valid), 32'd0);
      bus.core_done   = 1'b1;
      bus.core_result = 32'h4040_0000;
      cyc();                                   // T+3
      bus.core_done = 1'b0;
      chk("s_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("s_rsp_result", bus.rsp_result, 32'h4040_0000);
      chk("s_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("s_cnt_before", 32'(op_count), 32'd0);
      bus.rsp_ready = 4'b0001;
      cyc();
      bus.rsp_ready = '0;
      chk("s_op_count", 32'(op_count), 32'd1);
      chk("s_idle", 32'(busy), 32'd0);
      chk("s_rsp_drop", 32'(bus.rsp_valid), 32'd0);

      // Reset from IDLE, then round-robin with every requester valid
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("r_op_count", 32'(op_count), 32'd0);
      for (int i = 0; i < 4; i++) begin
         bus.req_a[i*32 +: 32] = ta[i];
         bus.req_b[i*32 +: 32] = tb[i];
         bus.req_op[i]         = 1'(i % 2);
      end
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 4'b1111;
      #1;
      rr_op(0, 32'hAAAA_0000);
      rr_op(1, 32'hAAAA_0001);
      rr_op(2, 32'hAAAA_0002);
      rr_op(3, 32'hAAAA_0003);
      rr_op(0, 32'hAAAA_0004);
      chk("rr_op_count", 32'(op_count), 32'd5);

      // Timeout on requester 2, then response backpressure
      bus.req_valid = 4'b0100;
      bus.rsp_ready = '0;
      #1;
      chk("t_req_ready", 32'(bus.req_ready), 32'h4);
      cyc();                                   // start cycle S
      chk("t_start", 32'(bus.core_start), 32'd1);
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 64; k++) cyc();      // S+64: last WAIT cycle
      chk("t_still_wait", 32'(bus.rsp_valid), 32'd0);
      cyc();                                   // S+65: RESP
      chk("t_rsp_valid", 32'(bus.rsp_valid), 32'h4);
      chk("t_rsp_result", bus.rsp_result, 32'h7FC0_0000);
      chk("t_rsp_err", 32'(bus.rsp_err), 32'd1);
      bus.rsp_ready = 4'b1011;                 // other requesters' ready ignored
      for (int k = 0; k < 10; k++) begin
         cyc();
         chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'h4);
         chk("bp_rsp_result", bus.rsp_result, 32'h7FC0_0000);
         chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
         chk("bp_start", 32'(bus.core_start), 32'd0);
      end
      bus.rsp_ready = 4'b0100;
      bus.req_valid = '0;
      cyc();
      bus.rsp_ready = '0;
      chk("t_op_count", 32'(op_count), 32'd6);
      chk("t_idle", 32'(busy), 32'd0);

      // core_done while IDLE is ignored
      bus.core_done   = 1'b1;
      bus.core_result = 32'h1234_5678;
      cyc();
      bus.core_done = 1'b0;
      chk("i_done_busy", 32'(busy), 32'd0);
      chk("i_done_rsp", 32'(bus.rsp_valid), 32'd0);

      // Done and timeout in the same cycle: the core result wins.
      // rr_ptr is 3, so requester 0 is found after wrapping.
      bus.req_valid = 4'b0001;
      #1;
      chk("tie_req_ready", 32'(bus.req_ready), 32'h1);
      cyc();
      bus.req_valid = '0;
      for (int k = 0; k < 64; k++) cyc();      // wait_cnt == 63
      bus.core_done   = 1'b1;
      bus.core_result = 32'hC0A0_0000;
      cyc();
      bus.core_done = 1'b0;
      chk("tie_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("tie_rsp_result", bus.rsp_result, 32'hC0A0_0000);
      chk("tie_rsp_err", 32'(bus.rsp_err), 32'd0);
      bus.rsp_ready = 4'b0001;
      cyc();
      bus.rsp_ready = '0;
      chk("tie_op_count", 32'(op_count), 32'd7);

      // Reset in the middle of WAIT, followed by a late core_done
      bus.req_valid = 4'b0010;
      #1;
      chk("m_req_ready", 32'(bus.req_ready), 32'h2);
      cyc();
      bus.req_valid = '0;
      cyc();
      cyc();
      chk("m_in_wait", 32'(busy), 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("m_busy", 32'(busy), 32'd0);
      chk("m_op_count", 32'(op_count), 32'd0);
      chk("m_core_a", bus.core_a, 32'd0);
      bus.core_done   = 1'b1;
      bus.core_result = 32'h4120_0000;
      bus.rsp_ready   = 4'b1111;
      cyc();
      bus.core_done = 1'b0;
      held = 32'(bus.rsp_valid);
      chk("m_late_rsp", held, 32'd0);
      chk("m_late_busy", 32'(busy), 32'd0);
      chk("m_late_result", bus.rsp_result, 32'd0);
      bus.rsp_ready = '0;
      bus.req_valid = 4'b1111;
      #1;
      chk("m_rr_ptr", 32'(bus.req_ready), 32'h1);
      bus.req_valid = '0;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
